instr_cache: RTL and testbench

INSTR_CACHE -- requirements
Module: instr_cache

---
 rtl/icache_pkg.sv | 16 +
 rtl/icache_data_array.sv | 26 ++
 rtl/instr_cache.sv | 146 ++++++++++++++
 tb/tb_instr_cache.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and constants for the direct-mapped instruction cache
package icache_pkg;

    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_BITS    = 2;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        RESPOND
    } state_t;

endpackage

// File: rtl/icache_data_array.sv
// rtl/icache_data_array.sv - LINES x 4 x 32 instruction word store, one write port, one async read port
module icache_data_array
    import icache_pkg::*;
#(
    parameter int LINES = 64
) (
    input  logic                       CLK,
    input  logic                       wrEn,
    input  logic [$clog2(LINES)-1:0]   wrLine,
    input  logic [OFFSET_BITS-1:0]     wrWord,
    input  word_t                      wrData,
    input  logic [$clog2(LINES)-1:0]   rdLine,
    input  logic [OFFSET_BITS-1:0]     rdWord,
    output word_t                      rdData
);

    word_t mem [LINES*WORDS_PER_LINE];

    always_ff @(posedge CLK) begin
        if (wrEn)
            mem[{wrLine, wrWord}] <= wrData;
    end

    assign rdData = mem[{rdLine, rdWord}];

endmodule

// File: rtl/instr_cache.sv
// rtl/instr_cache.sv - direct-mapped instruction cache with 4-word line refill
// Optional hit/miss counters are built when ICACHE_PERF_CNT_EN is defined.
module instr_cache
    import icache_pkg::*;
#(
    parameter int LINES = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PC,
    input  logic        InstrMemReadEnable,
    output logic        InstrMemAck,
    output word_t       Instr,
    input  logic        Flush,
    output addr_t       MemAddr,
    output logic        MemReadEnable,
    input  logic        MemAck,
    input  word_t       MemData,
    output logic [31:0] HitCount,
    output logic [31:0] MissCount
);

    localparam int INDEX_BITS = $clog2(LINES);
    localparam int TAG_BITS   = 32 - OFFSET_BITS - 2 - INDEX_BITS;

    typedef logic [INDEX_BITS-1:0] index_t;
    typedef logic [TAG_BITS-1:0]   tag_t;

    state_t                 state;
    logic [31:2]            reqPc;
    logic [OFFSET_BITS-1:0] cnt;
    logic                   flushPending;
    logic [LINES-1:0]       valid;
    tag_t                   tags [LINES];

    index_t pcIndex, reqIndex;
    tag_t   pcTag, reqTag;
    logic   accept, hit, memWrite, lastWord;
    word_t  rdData;
    logic   unusedPcBits;

    assign pcIndex      = PC[4 +: INDEX_BITS];
    assign pcTag        = PC[31 -: TAG_BITS];
    assign reqIndex     = reqPc[4 +: INDEX_BITS];
    assign reqTag       = reqPc[31 -: TAG_BITS];
    assign unusedPcBits = ^PC[1:0];

    assign accept   = (state == IDLE) && InstrMemReadEnable && !InstrMemAck;
    // A flush arriving with the request wins: the lookup is forced to miss.
    assign hit      = valid[pcIndex] && (tags[pcIndex] == pcTag) && !Flush;
    assign memWrite = (state == REFILL) && MemAck;
    assign lastWord = (cnt == OFFSET_BITS'(WORDS_PER_LINE - 1));

    icache_data_array #(.LINES(LINES)) dataArray (
        .CLK    (CLK),
        .wrEn   (memWrite),
        .wrLine (reqIndex),
        .wrWord (cnt),
        .wrData (MemData),
        .rdLine (pcIndex),
        .rdWord (PC[3:2]),
        .rdData (rdData)
    );

    always_ff @(posedge CLK) begin
        if (memWrite && lastWord)
            tags[reqIndex] <= reqTag;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            reqPc         <= '0;
            cnt           <= '0;
            flushPending  <= 1'b0;
            valid         <= '0;
            InstrMemAck   <= 1'b0;
            Instr         <= '0;
            MemAddr       <= '0;
            MemReadEnable <= 1'b0;
        end else begin
            InstrMemAck <= 1'b0;
            case (state)
                IDLE: begin
                    if (Flush)
                        valid <= '0;
                    if (accept) begin
                        reqPc <= PC[31:2];
                        if (hit) begin
                            InstrMemAck <= 1'b1;
                            Instr       <= rdData;
                        end else begin
                            state         <= REFILL;
                            cnt           <= '0;
                            MemReadEnable <= 1'b1;
                            MemAddr       <= {PC[31:4], 4'b0000};
                        end
                    end
                end
                REFILL: begin
                    if (Flush)
                        flushPending <= 1'b1;
                    if (MemAck) begin
                        // Capture the requested word as it streams past.
                        if (cnt == reqPc[3:2])
                            Instr <= MemData;
                        cnt     <= cnt + 2'd1;
                        MemAddr <= {reqPc[31:4], cnt + 2'd1, 2'b00};
                        if (lastWord) begin
                            MemReadEnable   <= 1'b0;
                            valid[reqIndex] <= 1'b1;
                            InstrMemAck     <= 1'b1;
                            state           <= RESPOND;
                        end
                    end
                end
                RESPOND: begin
                    state <= IDLE;
                    if (Flush || flushPending) begin
                        valid        <= '0;
                        flushPending <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            HitCount  <= '0;
            MissCount <= '0;
        end else if (accept) begin
            if (hit)
                HitCount <= HitCount + 32'd1;
            else
                MissCount <= MissCount + 32'd1;
        end
    end
`else
    assign HitCount  = '0;
    assign MissCount = '0;
`endif

endmodule

// File: tb/tb_instr_cache.sv
// tb/tb_instr_cache.sv - directed self-checking bench for instr_cache with a delay-programmable memory model
module tb_instr_cache;

`ifdef ICACHE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] PC = '0;
    logic        InstrMemReadEnable = 1'b0;
    logic        InstrMemAck;
    logic [31:0] Instr;
    logic        Flush = 1'b0;
    logic [31:0] MemAddr;
    logic        MemReadEnable;
    logic        MemAck;
    logic [31:0] MemData;
    logic [31:0] HitCount, MissCount;

    int checks = 0;
    int fails = 0;
    int memDelay = 0;
    int waitCnt = 0;
    int readCount = 0;
    int renCycles = 0;
    int doubleAck = 0;
    logic prevAck = 1'b0;
    logic [31:0] addrLog [$];

    instr_cache #(.LINES(64)) dut (
        .CLK                (CLK),
        .RST                (RST),
        .PC                 (PC),
        .InstrMemReadEnable (InstrMemReadEnable),
        .InstrMemAck        (InstrMemAck),
        .Instr              (Instr),
        .Flush              (Flush),
        .MemAddr            (MemAddr),
        .MemReadEnable      (MemReadEnable),
        .MemAck             (MemAck),
        .MemData            (MemData),
        .HitCount           (HitCount),
        .MissCount          (MissCount)
    );

    always #5 CLK = ~CLK;

    // Line 0x100 holds 0x11..0x14; every other word is its address xor a marker.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a[31:4] == 28'h10)
            return 32'h11 + {30'd0, a[3:2]};
        return a ^ 32'hA5A5_0000;
    endfunction

    assign MemData = memWord(MemAddr);
    assign MemAck  = MemReadEnable && (waitCnt == memDelay);

    always @(posedge CLK or negedge RST) begin
        if (!RST)
            waitCnt <= 0;
        else if (MemReadEnable && MemAck)
            waitCnt <= 0;
        else if (MemReadEnable)
            waitCnt <= waitCnt + 1;
    end

    always @(negedge CLK) begin
        if (MemReadEnable && MemAck) begin
            readCount++;
            addrLog.push_back(MemAddr);
        end
        if (MemReadEnable)
            renCycles++;
        if (InstrMemAck && prevAck)
            doubleAck++;
        prevAck = InstrMemAck;
    end

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] perfExp(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic fetch(input logic [31:0] pc, input bit changePc,
                         output logic [31:0] instr, output int lat, output logic ackAfter);
        @(negedge CLK);
        PC = pc;
        InstrMemReadEnable = 1'b1;
        @(posedge CLK);
        #1;
        lat = 1;
        if (changePc)
            PC = 32'hDEAD_BEE0;
        while (!InstrMemAck && lat < 400) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        if (!InstrMemAck)
            checkEq("fetchTimeout", 32'd0, 32'd1);
        instr = Instr;
        InstrMemReadEnable = 1'b0;
        @(posedge CLK);
        #1;
        ackAfter = InstrMemAck;
    endtask

    logic [31:0] instr;
    int lat;
    logic ackAfter;
    int r0, e0;
    int n;
    bit found;

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        checkEq("rstAck", {31'd0, InstrMemAck}, 32'd0);
        checkEq("rstMemRen", {31'd0, MemReadEnable}, 32'd0);
        checkEq("rstMemAddr", MemAddr, 32'd0);
        checkEq("rstInstr", Instr, 32'd0);
        checkEq("rstHit", HitCount, 32'd0);
        checkEq("rstMiss", MissCount, 32'd0);
        @(negedge CLK);
        RST = 1'b1;

        // Cold fetch of line 0x100 with zero-wait memory
        addrLog.delete();
        r0 = readCount;
        fetch(32'h100, 1'b0, instr, lat, ackAfter);
        checkEq("coldInstr", instr, 32'h11);
        checkEq("coldReads", 32'(readCount - r0), 32'd4);
        for (int i = 0; i < 4; i++)
            checkEq($sformatf("coldAddr%0d", i),
                    (addrLog.size() > i) ? addrLog[i] : 32'hFFFF_FFFF, 32'h100 + 32'(4 * i));
        checkEq("coldAckPulse", {31'd0, ackAfter}, 32'd0);
        checkEq("coldMissCnt", MissCount, perfExp(1));

        // Hit in the same line
        e0 = renCycles;
        fetch(32'h108, 1'b0, instr, lat, ackAfter);
        checkEq("hitInstr", instr, 32'h13);
        checkEq("hitLatency", 32'(lat), 32'd1);
        checkEq("hitNoMemRen", 32'(renCycles - e0), 32'd0);
        checkEq("hitCnt", HitCount, perfExp(1));

        // Flush in IDLE, then conflict misses on index 0x10
        @(negedge CLK);
        Flush = 1'b1;
        @(negedge CLK);
        Flush = 1'b0;
        r0 = readCount;
        fetch(32'h100, 1'b0, instr, lat, ackAfter);
        checkEq("conflictA", instr, 32'h11);
        fetch(32'h500, 1'b0, instr, lat, ackAfter);
        checkEq("conflictB", instr, 32'hA5A5_0500);
        fetch(32'h100, 1'b0, instr, lat, ackAfter);
        checkEq("conflictC", instr, 32'h11);
        checkEq("conflictReads", 32'(readCount - r0), 32'd12);
        checkEq("conflictMissCnt", MissCount, perfExp(4));

        // Flush arriving while the second word of 0x200 is being refilled
        r0 = readCount;
        found = 1'b0;
        fork
            fetch(32'h204, 1'b0, instr, lat, ackAfter);
            begin
                n = 0;
                while (n < 100 && !(MemReadEnable && MemAck && MemAddr == 32'h204)) begin
                    @(negedge CLK);
                    n++;
                end
                found = (n < 100);
                Flush = 1'b1;
                @(negedge CLK);
                Flush = 1'b0;
            end
        join
        checkEq("flushWindow", {31'd0, found}, 32'd1);
        checkEq("flushRespInstr", instr, 32'hA5A5_0204);
        fetch(32'h200, 1'b0, instr, lat, ackAfter);
        checkEq("flushThenInstr", instr, 32'hA5A5_0200);
        checkEq("flushThenReads", 32'(readCount - r0), 32'd8);

        // Reset in the middle of a slow refill of 0x300
        memDelay = 3;
        @(negedge CLK);
        PC = 32'h300;
        InstrMemReadEnable = 1'b1;
        n = 0;
        while (n < 100 && !(MemReadEnable && MemAddr == 32'h304)) begin
            @(negedge CLK);
            n++;
        end
        checkEq("midRefillReached", 32'(n < 100), 32'd1);
        RST = 1'b0;
        #1;
        checkEq("asyncRstMemRen", {31'd0, MemReadEnable}, 32'd0);
        checkEq("asyncRstMemAddr", MemAddr, 32'd0);
        checkEq("asyncRstAck", {31'd0, InstrMemAck}, 32'd0);
        checkEq("asyncRstInstr", Instr, 32'd0);
        checkEq("asyncRstMiss", MissCount, 32'd0);
        InstrMemReadEnable = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        r0 = readCount;
        fetch(32'h300, 1'b0, instr, lat, ackAfter);
        checkEq("postRstInstr", instr, 32'hA5A5_0300);
        checkEq("postRstReads", 32'(readCount - r0), 32'd4);

        // Slow memory, core moves PC right after acceptance
        r0 = readCount;
        fetch(32'h40C, 1'b1, instr, lat, ackAfter);
        checkEq("latchedPcInstr", instr, 32'hA5A5_040C);
        checkEq("latchedPcReads", 32'(readCount - r0), 32'd4);
        checkEq("latchedPcAckPulse", {31'd0, ackAfter}, 32'd0);
        checkEq("finalMissCnt", MissCount, perfExp(2));
        checkEq("finalHitCnt", HitCount, 32'd0);
        checkEq("noDoubleAck", 32'(doubleAck), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
